// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if : byte-stream valid/ready channel feeding the program loader
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface prog_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

`default_nettype wire

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader : assembles 10-bit words from a checksummed byte stream, writes
//               them to instruction memory and releases the CPU when verified
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prog_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int INST_W = 10
) (
  input  wire logic              clk_i,
  input  wire logic              rst_ni,
  prog_loader_if.slave           in_if,
  output logic                   mem_wren_o,
  output logic [ADDR_W-1:0]      mem_address_o,
  output logic [INST_W-1:0]      mem_data_o,
  output logic                   cpu_reset_o,
  output logic                   done_o,
  output logic                   error_o
);

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_WRITE = 3'd3,
    S_CHK   = 3'd4,
    S_RUN   = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [7:0]          chk_q, chk_d;
  logic [1:0]          hi_q, hi_d;
  logic                ready_q, ready_d;
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [INST_W-1:0]   data_q, data_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                xfer;
  logic [ADDR_W:0]     cnt_inc;

  assign xfer    = in_if.in_valid & ready_q;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_HDR: if (xfer) begin
        if (in_if.in_data == 8'd0 || in_if.in_data > DEPTH_B) begin
          state_d = S_ERR;
        end else begin
          n_d     = in_if.in_data[ADDR_W:0];
          cnt_d   = '0;
          chk_d   = '0;
          state_d = S_HI;
        end
      end
      S_HI: if (xfer) begin
        if (in_if.in_data[7:2] != 6'd0) begin
          state_d = S_ERR;
        end else begin
          hi_d    = in_if.in_data[1:0];
          chk_d   = chk_q ^ in_if.in_data;
          state_d = S_LO;
        end
      end
      S_LO: if (xfer) begin
        chk_d   = chk_q ^ in_if.in_data;
        data_d  = {hi_q, in_if.in_data};
        addr_d  = cnt_q[ADDR_W-1:0];
        state_d = S_WRITE;
      end
      S_WRITE: begin
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == n_q) ? S_CHK : S_HI;
      end
      S_CHK: if (xfer) begin
        state_d = (in_if.in_data == chk_q) ? S_RUN : S_ERR;
      end
      default: state_d = state_q;
    endcase

    // Every output is a registered function of the state being entered.
    ready_d   = (state_d == S_HDR) || (state_d == S_HI) ||
                (state_d == S_LO)  || (state_d == S_CHK);
    wren_d    = (state_d == S_WRITE);
    done_d    = (state_d == S_RUN);
    cpu_rst_d = (state_d == S_RUN);
    err_d     = (state_d == S_ERR);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_HDR;
      n_q       <= '0;
      cnt_q     <= '0;
      chk_q     <= '0;
      hi_q      <= '0;
      ready_q   <= 1'b0;
      wren_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      cpu_rst_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      chk_q     <= chk_d;
      hi_q      <= hi_d;
      ready_q   <= ready_d;
      wren_q    <= wren_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign in_if.in_ready = ready_q;
  assign mem_wren_o     = wren_q;
  assign mem_address_o  = addr_q;
  assign mem_data_o     = data_q;
  assign cpu_reset_o    = cpu_rst_q;
  assign done_o         = done_q;
  assign error_o        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader : directed self-checking bench for prog_loader
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_prog_loader;

  logic       clk;
  logic       rst_n;
  logic       mem_wren;
  logic [4:0] mem_address;
  logic [9:0] mem_data;
  logic       cpu_reset;
  logic       done;
  logic       error;

  prog_loader_if bus ();

  prog_loader #(.DEPTH(32), .ADDR_W(5), .INST_W(10)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_if        (bus.slave),
    .mem_wren_o   (mem_wren),
    .mem_address_o(mem_address),
    .mem_data_o   (mem_data),
    .cpu_reset_o  (cpu_reset),
    .done_o       (done),
    .error_o      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int stalls = 0;

  // Write log: the memory samples wren on the edge ending the pulse, so a
  // mid-cycle sample sees each one-cycle pulse exactly once.
  int         wr_cnt = 0;
  logic [4:0] wa [0:255];
  logic [9:0] wd [0:255];
  always @(negedge clk) begin
    if (mem_wren && wr_cnt < 256) begin
      wa[wr_cnt] = mem_address;
      wd[wr_cnt] = mem_data;
      wr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
      stalls++;
    end
    if (t >= 20) begin
      n_vec++;
      n_err++;
      $error("FAIL send_timeout: observed in_ready=0 for %0d cycles, expected 1", t);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int base;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst_n        = 1'b0;
    #12;
    check("rst_ready",  bus.in_ready, 0);
    check("rst_wren",   mem_wren,     0);
    check("rst_addr",   mem_address,  0);
    check("rst_data",   mem_data,     0);
    check("rst_cpurst", cpu_reset,    0);
    check("rst_done",   done,         0);
    check("rst_error",  error,        0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", bus.in_ready, 1);

    // Three-word image, checksum 01^55^00^AA^03^FF = 02
    base = wr_cnt;
    stalls = 0;
    send(8'h03);
    send(8'h01); send(8'h55);
    send(8'h00); send(8'hAA);
    send(8'h03); send(8'hFF);
    check("img3_cpurst_before_chk", cpu_reset, 0);
    send(8'h02);
    check("img3_done",   done,      1);
    check("img3_cpurst", cpu_reset, 1);
    check("img3_error",  error,     0);
    check("img3_ready",  bus.in_ready, 0);
    check("img3_nwrites", wr_cnt - base, 3);
    check("img3_a0", wa[base],   5'd0);  check("img3_d0", wd[base],   10'h155);
    check("img3_a1", wa[base+1], 5'd1);  check("img3_d1", wd[base+1], 10'h0AA);
    check("img3_a2", wa[base+2], 5'd2);  check("img3_d2", wd[base+2], 10'h3FF);
    check("img3_stalls", stalls, 3);

    // Same image, bad checksum
    do_reset();
    base = wr_cnt;
    send(8'h03);
    send(8'h01); send(8'h55);
    send(8'h00); send(8'hAA);
    send(8'h03); send(8'hFF);
    send(8'h2B);
    check("badchk_error",  error,        1);
    check("badchk_cpurst", cpu_reset,    0);
    check("badchk_done",   done,         0);
    check("badchk_ready",  bus.in_ready, 0);
    check("badchk_nwrites", wr_cnt - base, 3);

    // Header 0 and header 33 are rejected without any write
    do_reset();
    base = wr_cnt;
    send(8'h00);
    check("hdr00_error", error, 1);
    check("hdr00_ready", bus.in_ready, 0);
    repeat (3) @(negedge clk);
    check("hdr00_nwrites", wr_cnt - base, 0);

    do_reset();
    base = wr_cnt;
    send(8'h21);
    check("hdr21_error", error, 1);
    check("hdr21_cpurst", cpu_reset, 0);
    repeat (3) @(negedge clk);
    check("hdr21_nwrites", wr_cnt - base, 0);

    // Full-depth image, word k = k, XOR of 0..31 = 00
    do_reset();
    base = wr_cnt;
    stalls = 0;
    send(8'h20);
    for (int k = 0; k < 32; k++) begin
      send(8'h00);
      send(8'(k));
    end
    send(8'h00);
    check("full_done",   done,      1);
    check("full_cpurst", cpu_reset, 1);
    check("full_error",  error,     0);
    check("full_stalls", stalls, 32);
    repeat (3) @(negedge clk);
    check("full_nwrites", wr_cnt - base, 32);
    for (int k = 0; k < 32; k++) begin
      check($sformatf("full_a%0d", k), wa[base+k], 32'(k));
      check($sformatf("full_d%0d", k), wd[base+k], 32'(k));
    end

    // Illegal high bits in the hi byte of word 0
    do_reset();
    base = wr_cnt;
    send(8'h01);
    send(8'h04);
    check("hibad_error", error, 1);
    check("hibad_ready", bus.in_ready, 0);
    repeat (3) @(negedge clk);
    check("hibad_nwrites", wr_cnt - base, 0);

    // Asynchronous abort during the second word's write cycle
    do_reset();
    base = wr_cnt;
    send(8'h03);
    send(8'h01); send(8'h55);
    send(8'h00); send(8'hAA);
    check("abort_wren_pre", mem_wren, 1);
    rst_n = 1'b0;
    #1;
    check("abort_wren",   mem_wren,     0);
    check("abort_addr",   mem_address,  0);
    check("abort_data",   mem_data,     0);
    check("abort_ready",  bus.in_ready, 0);
    check("abort_cpurst", cpu_reset,    0);
    check("abort_done",   done,         0);
    check("abort_error",  error,        0);
    @(negedge clk);
    check("abort_nwrites", wr_cnt - base, 1);
    rst_n = 1'b1;
    base = wr_cnt;
    send(8'h01);
    send(8'h00); send(8'h07);
    send(8'h07);
    check("reload_done",   done,      1);
    check("reload_cpurst", cpu_reset, 1);
    check("reload_nwrites", wr_cnt - base, 1);
    check("reload_a0", wa[base], 5'd0);
    check("reload_d0", wd[base], 10'h007);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
